// File: rtl/opb_reg_pkg.sv
// Shared definitions for small OPB slave registers: ack FSM states, register word offsets
// and the STATUS word layout.
package opb_reg_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StAck  = 2'd1,
    StWait = 2'd2
  } ack_state_e;

  // Word index taken from OPB_ABus[24:29]
  localparam logic [5:0] OFF_DATA   = 6'h00;
  localparam logic [5:0] OFF_STATUS = 6'h01;

  localparam int unsigned STATUS_NEW_BIT = 31;
  localparam int unsigned STATUS_OVF_BIT = 30;
  localparam int unsigned DROP_CNT_W     = 16;

  // Big-endian bus index of the clear request; OPB_DBus[1] carries value bit 30
  localparam int unsigned STATUS_CLR_IDX = 1;

  function automatic logic [31:0] pack_status(input logic                  is_new,
                                              input logic                  ovf,
                                              input logic [DROP_CNT_W-1:0] cnt);
    logic [31:0] s;
    s = '0;
    s[STATUS_NEW_BIT]   = is_new;
    s[STATUS_OVF_BIT]   = ovf;
    s[DROP_CNT_W-1:0]   = cnt;
    return s;
  endfunction

endpackage

// File: rtl/opb_register_simulink2ppc_if.sv
// OPB master/slave signal bundle. Signal names keep the OPB bus naming; vectors are big-endian
// ([0] is the most significant bit).
interface opb_register_simulink2ppc_if #(
  parameter int unsigned AWidth = 32,
  parameter int unsigned DWidth = 32
);

  logic [0:AWidth-1]   OPB_ABus;
  logic [0:DWidth/8-1] OPB_BE;
  logic [0:DWidth-1]   OPB_DBus;
  logic                OPB_RNW;
  logic                OPB_select;
  logic                OPB_seqAddr;

  logic [0:DWidth-1]   Sl_DBus;
  logic                Sl_xferAck;
  logic                Sl_errAck;
  logic                Sl_retry;
  logic                Sl_toutSup;

  modport master (
    output OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
    input  Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
  );

  modport slave (
    input  OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
    output Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
  );

endinterface

// File: rtl/opb_slave_ack_fsm.sv
// Reusable OPB slave address decode and single-beat ack FSM (Idle -> Ack -> Wait).
// Latches the word offset and direction of the accepted transfer for the Ack cycle.
module opb_slave_ack_fsm
  import opb_reg_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR   = 32'h00000000,
  parameter logic [31:0] C_HIGHADDR   = 32'h000000FF,
  parameter int unsigned C_OPB_AWIDTH = 32
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_select,
  input  logic                    i_rnw,
  input  logic [0:C_OPB_AWIDTH-1] i_abus,
  output logic                    o_ack,
  output logic                    o_rnw,
  output logic [5:0]              o_offset
);

  localparam logic [31:0] Span = C_HIGHADDR - C_BASEADDR;

  ack_state_e  r_state;
  ack_state_e  w_state_next;
  logic        r_armed;
  logic        r_rnw;
  logic [5:0]  r_offset;
  logic [31:0] w_rel;
  logic        w_hit;
  logic        w_accept;

  // Addresses below the base wrap to a large value, so one compare covers both window edges
  assign w_rel = i_abus - C_BASEADDR;
  assign w_hit = i_select && (w_rel <= Span);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= StIdle;
      r_armed  <= 1'b0;
      r_rnw    <= 1'b0;
      r_offset <= '0;
    end else begin
      r_state <= w_state_next;
      // A select still high across reset release belongs to an abandoned transfer
      r_armed <= r_armed | ~i_select;
      if (w_accept) begin
        r_rnw    <= i_rnw;
        r_offset <= i_abus[24:29];
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_hit && r_armed) begin
          w_state_next = StAck;
          w_accept     = 1'b1;
        end
      end
      StAck:  w_state_next = StWait;
      StWait: begin
        if (!i_select) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  assign o_ack    = (r_state == StAck);
  assign o_rnw    = r_rnw;
  assign o_offset = r_offset;

endmodule

// File: rtl/opb_register_simulink2ppc.sv
// Fabric-to-PowerPC OPB register: latches user_data_in on user_valid and exposes it with a
// NEW/OVF status word. Define OPB_S2P_DROP_CNT_EN to add a saturating 16-bit drop counter.
module opb_register_simulink2ppc
  import opb_reg_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR   = 32'h00000000,
  parameter logic [31:0] C_HIGHADDR   = 32'h000000FF,
  parameter int unsigned C_OPB_AWIDTH = 32,
  parameter int unsigned C_OPB_DWIDTH = 32,
  parameter string       C_FAMILY     = "virtex6"
) (
  input  logic                              OPB_Clk,
  input  logic                              OPB_Rst_n,
  opb_register_simulink2ppc_if.slave        bus,
  input  logic [31:0]                       user_data_in,
  input  logic                              user_valid
);

  logic                  w_ack;
  logic                  w_rnw;
  logic [5:0]            w_offset;
  logic [31:0]           r_data;
  logic                  r_new;
  logic                  r_ovf;
  logic [DROP_CNT_W-1:0] w_drop_cnt;
  logic                  w_data_rd;
  logic                  w_stat_clr;
  logic                  w_overflow;
  logic [31:0]           w_rdata;
  logic                  w_unused;

  opb_slave_ack_fsm #(
    .C_BASEADDR   (C_BASEADDR),
    .C_HIGHADDR   (C_HIGHADDR),
    .C_OPB_AWIDTH (C_OPB_AWIDTH)
  ) u_ack_fsm (
    .i_clk    (OPB_Clk),
    .i_rst_n  (OPB_Rst_n),
    .i_select (bus.OPB_select),
    .i_rnw    (bus.OPB_RNW),
    .i_abus   (bus.OPB_ABus),
    .o_ack    (w_ack),
    .o_rnw    (w_rnw),
    .o_offset (w_offset)
  );

  assign w_data_rd  = w_ack && w_rnw && (w_offset == OFF_DATA);
  assign w_stat_clr = w_ack && !w_rnw && (w_offset == OFF_STATUS) &&
                      bus.OPB_DBus[STATUS_CLR_IDX];
  // A strobe racing the data read's ack is handed over, not dropped
  assign w_overflow = user_valid && r_new && !w_data_rd;

  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      r_data <= '0;
      r_new  <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      if (user_valid) begin
        r_data <= user_data_in;
        r_new  <= 1'b1;
      end else if (w_data_rd) begin
        r_new  <= 1'b0;
      end
      if (w_overflow) begin
        r_ovf <= 1'b1;
      end else if (w_stat_clr) begin
        r_ovf <= 1'b0;
      end
    end
  end

`ifdef OPB_S2P_DROP_CNT_EN
  logic [DROP_CNT_W-1:0] r_drop_cnt;

  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      r_drop_cnt <= '0;
    end else if (w_stat_clr) begin
      r_drop_cnt <= {{(DROP_CNT_W-1){1'b0}}, w_overflow};
    end else if (w_overflow && (r_drop_cnt != {DROP_CNT_W{1'b1}})) begin
      r_drop_cnt <= r_drop_cnt + DROP_CNT_W'(1);
    end
  end

  assign w_drop_cnt = r_drop_cnt;
`else
  assign w_drop_cnt = '0;
`endif

  // Wired-OR bus: drive zeros everywhere except the ack cycle of a read
  always_comb begin
    w_rdata = '0;
    if (w_ack && w_rnw) begin
      case (w_offset)
        OFF_DATA:   w_rdata = r_data;
        OFF_STATUS: w_rdata = pack_status(r_new, r_ovf, w_drop_cnt);
        default:    w_rdata = '0;
      endcase
    end
  end

  assign bus.Sl_DBus    = w_rdata;
  assign bus.Sl_xferAck = w_ack;
  assign bus.Sl_errAck  = 1'b0;
  assign bus.Sl_retry   = 1'b0;
  assign bus.Sl_toutSup = 1'b0;

  assign w_unused = ^{bus.OPB_BE, bus.OPB_seqAddr, bus.OPB_DBus[0],
                      bus.OPB_DBus[2:C_OPB_DWIDTH-1], (C_OPB_DWIDTH == 32), (C_FAMILY == "")};

endmodule

// File: doc/opb_register_simulink2ppc.md
OPB_REGISTER_SIMULINK2PPC -- requirements
Module: opb_register_simulink2ppc

Interface
REQ-001 SHALL have parameter C_BASEADDR, default 32'h00000000, first byte address of the 256-byte slave window.
REQ-002 SHALL have parameter C_HIGHADDR, default 32'h000000FF, last byte address of the window.
REQ-003 SHALL have parameter C_OPB_AWIDTH, default 32, OPB address width.
REQ-004 SHALL have parameter C_OPB_DWIDTH, default 32, OPB data width.
REQ-005 SHALL have parameter C_FAMILY, default "virtex6", target family string, not otherwise used.
REQ-006 SHALL have port OPB_Clk, input, 1, the single clock; one clock, all logic on its rising edge.
REQ-007 SHALL have port OPB_Rst_n, input, 1, reset, asynchronous and active-low.
REQ-008 SHALL have port OPB_ABus, input, [0:31], bus address.
REQ-009 SHALL have port OPB_BE, input, [0:3], byte enables, ignored; full-word access.
REQ-010 SHALL have port OPB_DBus, input, [0:31], write data.
REQ-011 SHALL have ports OPB_RNW, input, 1, read-not-write; and OPB_select, input, 1, transfer request.
REQ-012 SHALL have port OPB_seqAddr, input, 1, ignored; every beat is a single transfer.
REQ-013 SHALL have port Sl_DBus, output, [0:31], read data.
REQ-014 SHALL have port Sl_xferAck, output, 1, transfer acknowledge.
REQ-015 SHALL have ports Sl_errAck, Sl_retry and Sl_toutSup, outputs, 1 each, all tied 0.
REQ-016 SHALL have port user_data_in, input, [31:0], fabric value.
REQ-017 SHALL have port user_valid, input, 1, capture strobe for user_data_in.

Function
REQ-018 SHALL decode a hit as OPB_select=1 with C_BASEADDR <= OPB_ABus <= C_HIGHADDR; offset = OPB_ABus[24:29].
REQ-019 SHALL use ack FSM states IDLE, ACK, WAIT: IDLE->ACK on hit; ACK->WAIT unconditionally; WAIT->IDLE when OPB_select=0.
REQ-020 SHALL assert Sl_xferAck for exactly one cycle, in state ACK, which is one cycle after the hit is sampled.
REQ-021 SHALL drive Sl_DBus=0 except in the ACK cycle of a read; OPB is a wired-OR bus.
REQ-022 SHALL map value bit 31 to Sl_DBus[0] and value bit 0 to Sl_DBus[31].
REQ-023 SHALL, on user_valid=1, load DATA_REG<=user_data_in and set NEW=1; a later strobe overwrites, so the latest value wins.
REQ-024 SHALL return DATA_REG on a read at offset 0x00; the ACK cycle of that read clears NEW.
REQ-025 SHALL return STATUS on a read at offset 0x04: bit31=NEW, bit30=OVF, bits[15:0]=drop count (0 when REQ-034 is absent), other bits 0.
REQ-026 SHALL set sticky OVF when user_valid=1 while NEW=1 and no data read is in ACK.
REQ-027 SHALL, for user_valid coinciding with the ACK of a data read: return the old DATA_REG, leave NEW=1 holding the new data, and leave OVF unchanged.
REQ-028 SHALL, on a write at offset 0x04 with OPB_DBus[1]=1, clear OVF and the drop count; user_valid in the same cycle takes priority and sets OVF.
REQ-029 SHALL ack writes to any other offset and ignore their data, and SHALL return 0 for reads of unmapped offsets.
REQ-030 SHALL not generate a second ack while in WAIT, even if OPB_select stays high.

Reset
REQ-031 SHALL, while OPB_Rst_n=0, asynchronously force FSM=IDLE, DATA_REG=0, NEW=0, OVF=0, drop count=0, Sl_xferAck=0 and Sl_DBus=0.
REQ-032 SHALL abandon any in-flight transfer on a mid-transfer reset and issue no ack.
REQ-033 SHALL, after reset release, require OPB_select to be sampled low before accepting a new hit.

Configuration
REQ-034 SHALL, with macro OPB_S2P_DROP_CNT_EN defined, implement a 16-bit drop counter that increments under the REQ-026 condition, saturates at 0xFFFF and is cleared by REQ-028.
REQ-035 SHALL, without OPB_S2P_DROP_CNT_EN, instantiate no counter, so STATUS[15:0]=0.

Structure
REQ-036 SHALL place the FSM state enum, offsets OFF_DATA=6'h00 and OFF_STATUS=6'h01 (word index), and STATUS bit positions in shared package opb_reg_pkg.
REQ-037 SHALL implement the address decode and ack FSM in sub-module opb_slave_ack_fsm, reusable by other OPB registers.

Verification
REQ-038 SHALL cover: user_valid with 0xDEADBEEF, then read 0x00 -> Sl_xferAck 1 cycle after select, Sl_DBus=0xDEADBEEF, then STATUS=0x00000000.
REQ-039 SHALL cover: two strobes 0x1 then 0x2 without a read -> data read returns 0x2; STATUS=0xC0000001 with the macro, 0xC0000000 without.
REQ-040 SHALL cover: strobe 0x5 in the ACK cycle of a data read that returns 0x4 -> STATUS bit31=1, OVF=0, next data read returns 0x5.
REQ-041 SHALL cover: write 0x40000000 to 0x04 after an overflow -> STATUS bit30=0 and count=0.
REQ-042 SHALL cover: select held 5 cycles -> exactly one ack; access outside the window -> no ack; Sl_DBus=0 outside ACK.
REQ-043 SHALL cover: OPB_Rst_n low during ACK -> Sl_xferAck drops immediately, registers read 0 after release.
